// File: rtl/alu_pattern_player.sv
// Replays stored test vectors into the alu under test: drives PI, waits a settle time,
// strobes PO, compares under mask and accumulates pass/fail, fail count and first failure.
module alu_pattern_player #(
  parameter int NINPUTS       = 5,
  parameter int NOUTPUTS      = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int IDX_W         = 16,
  parameter int FAIL_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pat_valid,
  output logic                pat_ready,
  input  logic [NINPUTS-1:0]  pat_pi,
  input  logic [NOUTPUTS-1:0] pat_xpct,
  input  logic [NOUTPUTS-1:0] pat_mask,
  input  logic                pat_last,
  output logic [NINPUTS-1:0]  dut_pi,
  input  logic [NOUTPUTS-1:0] dut_po,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [IDX_W-1:0]    pattern_idx,
  output logic [FAIL_W-1:0]   fail_count,
  output logic                first_fail_vld,
  output logic [IDX_W-1:0]    first_fail_idx,
  output logic [NOUTPUTS-1:0] first_fail_bits
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SETTLE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NINPUTS-1:0]  pi_q, pi_d;
  logic [NOUTPUTS-1:0] xpct_q, xpct_d;
  logic [NOUTPUTS-1:0] mask_q, mask_d;
  logic                last_q, last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                ffv_q, ffv_d;
  logic [IDX_W-1:0]    ffi_q, ffi_d;
  logic [NOUTPUTS-1:0] ffb_q, ffb_d;
  logic [NOUTPUTS-1:0] mis;

  // Masked-off bits are forced to zero, so X/Z on don't-care outputs never count.
  assign mis = (dut_po ^ xpct_q) & mask_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pi_d    = pi_q;
    xpct_d  = xpct_q;
    mask_d  = mask_q;
    last_d  = last_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    ffb_d   = ffb_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          fail_d  = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
          ffb_d   = '0;
        end
      end
      S_FETCH: begin
        if (pat_valid) begin
          pi_d    = pat_pi;
          xpct_d  = pat_xpct;
          mask_d  = pat_mask;
          last_d  = pat_last;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          if (mis != '0) begin
            if (fail_q != '1) fail_d = fail_q + FAIL_W'(1);
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = idx_q;
              ffb_d = mis;
            end
          end
          idx_d   = idx_q + IDX_W'(1);
          state_d = last_q ? S_DONE : S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pi_q    <= '0;
      xpct_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      fail_q  <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      ffb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pi_q    <= pi_d;
      xpct_q  <= xpct_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      ffb_q   <= ffb_d;
    end
  end

  assign pat_ready       = (state_q == S_FETCH);
  assign busy            = (state_q == S_FETCH) || (state_q == S_SETTLE);
  assign done            = (state_q == S_DONE);
  assign pass            = (state_q == S_DONE) && (fail_q == '0);
  assign dut_pi          = pi_q;
  assign pattern_idx     = idx_q;
  assign fail_count      = fail_q;
  assign first_fail_vld  = ffv_q;
  assign first_fail_idx  = ffi_q;
  assign first_fail_bits = ffb_q;

endmodule

// File: tb/tb_alu_pattern_player.sv
// Directed bench for alu_pattern_player: golden alu replay, forced failures, masking,
// stalls, mid-run reset and fail-counter saturation on a narrow second instance.
module tb_alu_pattern_player;

  localparam int S  = 10;
  localparam int S2 = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, pat_valid, pat_last;
  logic [4:0]  pat_pi;
  logic [1:0]  pat_xpct, pat_mask;
  logic        pat_ready, busy, done, pass, first_fail_vld;
  logic [4:0]  dut_pi;
  logic [1:0]  dut_po, alu_po, po_force, first_fail_bits;
  logic        force_en;
  logic [15:0] pattern_idx, fail_count, first_fail_idx;

  logic        start2, valid2, last2, ready2, busy2, done2, pass2, ffv2;
  logic [4:0]  pi2, dut_pi2;
  logic [1:0]  xpct2, mask2, po2, ffb2, fail2;
  logic [15:0] idx2, ffi2;

  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden alu: sel=1 -> ain & bin, sel=0 -> ain ^ bin.
  always_comb begin
    alu_po = dut_pi[0] ? (dut_pi[4:3] & dut_pi[2:1]) : (dut_pi[4:3] ^ dut_pi[2:1]);
    dut_po = force_en ? po_force : alu_po;
  end

  alu_pattern_player #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
    .dut_pi(dut_pi), .dut_po(dut_po), .busy(busy), .done(done), .pass(pass),
    .pattern_idx(pattern_idx), .fail_count(fail_count), .first_fail_vld(first_fail_vld),
    .first_fail_idx(first_fail_idx), .first_fail_bits(first_fail_bits)
  );

  alu_pattern_player #(.SETTLE_CYCLES(S2), .FAIL_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .pat_valid(valid2), .pat_ready(ready2),
    .pat_pi(pi2), .pat_xpct(xpct2), .pat_mask(mask2), .pat_last(last2),
    .dut_pi(dut_pi2), .dut_po(po2), .busy(busy2), .done(done2), .pass(pass2),
    .pattern_idx(idx2), .fail_count(fail2), .first_fail_vld(ffv2),
    .first_fail_idx(ffi2), .first_fail_bits(ffb2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_vec(input logic [4:0] pi, input logic [1:0] x, input logic [1:0] m,
                          input logic l);
    int n = 0;
    pat_pi = pi; pat_xpct = x; pat_mask = m; pat_last = l; pat_valid = 1'b1;
    while (!pat_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pat_ready) check_eq("ready_timeout", 32'(pat_ready), 1);
    @(posedge clk); #1;
    pat_valid = 1'b0;
    prev_acc = acc_cyc;
    acc_cyc = cyc;
  endtask

  // Strobe must land exactly S edges after the load edge.
  task automatic wait_strobe(input string tag);
    logic [15:0] old;
    old = pattern_idx;
    repeat (S - 1) @(posedge clk);
    #1;
    check_eq({tag, "_early"}, 32'(pattern_idx), 32'(old));
    @(posedge clk); #1;
    check_eq({tag, "_strobe"}, 32'(pattern_idx), 32'(old + 16'd1));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, 32'(done), 1);
  endtask

  logic [4:0] vpi [10];
  logic [1:0] vx  [10];
  logic [4:0] hold_pi;

  initial begin
    vpi[0] = 5'b11101; vx[0] = 2'b10;
    vpi[1] = 5'b00000; vx[1] = 2'b00;
    vpi[2] = 5'b01010; vx[2] = 2'b00;
    vpi[3] = 5'b01011; vx[3] = 2'b01;
    vpi[4] = 5'b10010; vx[4] = 2'b11;
    vpi[5] = 5'b11111; vx[5] = 2'b11;
    vpi[6] = 5'b11110; vx[6] = 2'b00;
    vpi[7] = 5'b10101; vx[7] = 2'b10;
    vpi[8] = 5'b00111; vx[8] = 2'b00;
    vpi[9] = 5'b00110; vx[9] = 2'b11;

    rst_n = 1'b0; start = 1'b0; pat_valid = 1'b0; pat_last = 1'b0;
    pat_pi = '0; pat_xpct = '0; pat_mask = '0; force_en = 1'b0; po_force = '0;
    start2 = 1'b0; valid2 = 1'b0; last2 = 1'b0; pi2 = '0; xpct2 = 2'b11; mask2 = 2'b11;
    po2 = 2'b00;

    #12;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_pass", 32'(pass), 0);
    check_eq("rst_ready", 32'(pat_ready), 0);
    check_eq("rst_dut_pi", 32'(dut_pi), 0);
    check_eq("rst_idx", 32'(pattern_idx), 0);
    check_eq("rst_fail", 32'(fail_count), 0);
    check_eq("rst_ffv", 32'(first_fail_vld), 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_ready", 32'(pat_ready), 0);

    // Test 1: golden replay of ten vectors.
    pulse_start();
    check_eq("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      send_vec(vpi[i], vx[i], 2'b11, i == 9);
      wait_strobe($sformatf("t1_v%0d", i));
      if (i == 2) check_eq("t1_throughput", 32'(acc_cyc - prev_acc), 32'(S + 1));
    end
    wait_done("t1_done");
    check_eq("t1_pass", 32'(pass), 1);
    check_eq("t1_idx", 32'(pattern_idx), 10);
    check_eq("t1_fail", 32'(fail_count), 0);
    check_eq("t1_ffv", 32'(first_fail_vld), 0);
    check_eq("t1_busy_done", 32'(busy), 0);
    check_eq("t1_hold_pi", 32'(dut_pi), 32'(5'b00110));

    // Test 2: vector 0 forced to 00 while 10 is expected.
    pulse_start();
    check_eq("t2_done_clr", 32'(done), 0);
    check_eq("t2_idx_clr", 32'(pattern_idx), 0);
    force_en = 1'b1; po_force = 2'b00;
    send_vec(vpi[0], vx[0], 2'b11, 1'b0);
    wait_strobe("t2_v0");
    force_en = 1'b0;
    for (int i = 1; i < 4; i++) begin
      send_vec(vpi[i], vx[i], 2'b11, i == 3);
      wait_strobe($sformatf("t2_v%0d", i));
    end
    wait_done("t2_done");
    check_eq("t2_fail", 32'(fail_count), 1);
    check_eq("t2_ffv", 32'(first_fail_vld), 1);
    check_eq("t2_ffi", 32'(first_fail_idx), 0);
    check_eq("t2_ffb", 32'(first_fail_bits), 32'(2'b10));
    check_eq("t2_pass", 32'(pass), 0);
    check_eq("t2_hold_pi", 32'(dut_pi), 32'(5'b01011));

    // Test 3: low bit is don't-care and driven unknown.
    pulse_start();
    force_en = 1'b1; po_force = 2'b1x;
    send_vec(5'b11101, 2'b10, 2'b10, 1'b1);
    wait_strobe("t3_v0");
    force_en = 1'b0;
    wait_done("t3_done");
    check_eq("t3_pass", 32'(pass), 1);
    check_eq("t3_fail", 32'(fail_count), 0);
    check_eq("t3_ffv", 32'(first_fail_vld), 0);

    // Test 4: three idle cycles between vectors.
    pulse_start();
    send_vec(vpi[4], vx[4], 2'b11, 1'b0);
    check_eq("t4_pi_load", 32'(dut_pi), 32'(vpi[4]));
    wait_strobe("t4_v0");
    hold_pi = dut_pi;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("t4_ready%0d", i), 32'(pat_ready), 1);
      check_eq($sformatf("t4_pi%0d", i), 32'(dut_pi), 32'(hold_pi));
      check_eq($sformatf("t4_idx%0d", i), 32'(pattern_idx), 1);
    end
    send_vec(vpi[7], vx[7], 2'b11, 1'b1);
    wait_strobe("t4_v1");
    wait_done("t4_done");
    check_eq("t4_pass", 32'(pass), 1);
    check_eq("t4_idx", 32'(pattern_idx), 2);

    // Test 5: asynchronous reset in the middle of vector 2 settling.
    pulse_start();
    send_vec(vpi[0], vx[0], 2'b11, 1'b0);
    wait_strobe("t5_v0");
    send_vec(vpi[1], vx[1], 2'b11, 1'b0);
    wait_strobe("t5_v1");
    send_vec(vpi[2], 2'b11, 2'b11, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_ready", 32'(pat_ready), 0);
    check_eq("t5_dut_pi", 32'(dut_pi), 0);
    check_eq("t5_idx", 32'(pattern_idx), 0);
    check_eq("t5_fail", 32'(fail_count), 0);
    check_eq("t5_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    check_eq("t5_restart_idx", 32'(pattern_idx), 0);
    send_vec(vpi[5], vx[5], 2'b11, 1'b0);
    wait_strobe("t5_r0");
    send_vec(vpi[6], vx[6], 2'b11, 1'b1);
    wait_strobe("t5_r1");
    wait_done("t5_rdone");
    check_eq("t5_ridx", 32'(pattern_idx), 2);
    check_eq("t5_rpass", 32'(pass), 1);

    // Test 6: 2-bit fail counter with five failing vectors.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      pi2 = 5'(i + 1); last2 = (i == 4); valid2 = 1'b1;
      while (!ready2 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (!ready2) check_eq("t6_ready_timeout", 32'(ready2), 1);
      @(posedge clk); #1;
      valid2 = 1'b0;
    end
    begin
      int n = 0;
      while (!done2 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check_eq("t6_done", 32'(done2), 1);
    check_eq("t6_fail_sat", 32'(fail2), 3);
    check_eq("t6_ffi", 32'(ffi2), 0);
    check_eq("t6_ffb", 32'(ffb2), 32'(2'b11));
    check_eq("t6_idx", 32'(idx2), 5);
    check_eq("t6_pass", 32'(pass2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
